// File: rtl/lif_neuron_core.sv
// lif_neuron_core: time-stepped leaky-integrate-and-fire neuron array.
//
// Input spike events add signed weights to per-neuron 16-bit membrane potentials. A rising edge
// on the step control bit starts a sweep over all neurons. The sweep visits one neuron per cycle
// and applies the refractory, fire and leak rules. Fires are emitted on a valid/ready stream in
// ascending id order. The sweep pauses until each emitted spike is accepted.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   ctrl_reg            bit0 enable, bit1 soft_reset (level), bit2 step (rising edge)
//   leak_rate           unsigned per-timestep potential decrement
//   threshold           unsigned fire threshold
//   refractory_period   timesteps a neuron is held after firing
//   s_spike_*           input event stream (id, signed weight)
//   m_spike_*           output spike stream (firing neuron id)
//   status_reg          {timestep_count, 11'b0, step_overrun, clearing, emit_wait, sweeping, busy}
//   spike_count         total fires, wraps at 2^32
module lif_neuron_core #(
  parameter int unsigned NUM_NEURONS = 64,
  parameter int unsigned ID_W        = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ctrl_reg,
  input  logic [15:0]     leak_rate,
  input  logic [15:0]     threshold,
  input  logic [15:0]     refractory_period,
  input  logic            s_spike_valid,
  output logic            s_spike_ready,
  input  logic [ID_W-1:0] s_spike_id,
  input  logic [15:0]     s_spike_weight,
  output logic            m_spike_valid,
  input  logic            m_spike_ready,
  output logic [ID_W-1:0] m_spike_id,
  output logic [31:0]     status_reg,
  output logic [31:0]     spike_count
);

  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_NEURONS - 1);
  localparam logic [ID_W:0]   NumIds  = (ID_W + 1)'(NUM_NEURONS);

  typedef enum logic [1:0] {StIdle, StSweep, StEmit, StClear} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic [15:0]     v_q   [NUM_NEURONS];
  logic [15:0]     v_d   [NUM_NEURONS];
  logic [15:0]     ref_q [NUM_NEURONS];
  logic [15:0]     ref_d [NUM_NEURONS];
  logic            step_prev_q;
  logic            ready_q, ready_d;
  logic            m_valid_q, m_valid_d;
  logic [ID_W-1:0] m_id_q, m_id_d;
  logic [31:0]     spike_cnt_q, spike_cnt_d;
  logic [15:0]     ts_q, ts_d;
  logic            ovr_q, ovr_d;
  logic [31:0]     status_q, status_d;

  logic        enable, soft_rst, step_rise;
  logic        last_idx, fire, evt_accept, id_in_range, emit_done;
  logic [15:0] cur_v, cur_ref, leaked, sat_sum;
  logic signed [17:0] sum_wide;
  logic        unused_ctrl;

  assign enable      = ctrl_reg[0];
  assign soft_rst    = ctrl_reg[1];
  assign step_rise   = ctrl_reg[2] & ~step_prev_q;
  assign unused_ctrl = ^ctrl_reg[31:3];

  assign last_idx    = (idx_q == LastIdx);
  assign cur_v       = v_q[idx_q];
  assign cur_ref     = ref_q[idx_q];
  assign fire        = (state_q == StSweep) && (cur_ref == '0) && (cur_v >= threshold);
  // ready_q is only ever high while in IDLE, so it qualifies the handshake on its own
  assign evt_accept  = s_spike_valid & ready_q;
  assign id_in_range = ({1'b0, s_spike_id} < NumIds);
  assign emit_done   = (state_q == StEmit) && m_valid_q && m_spike_ready;

  // Integration arithmetic: 18-bit signed sum, clamped to [0, 65535]
  always_comb begin
    sum_wide = $signed({2'b00, v_q[s_spike_id]}) +
               $signed({{2{s_spike_weight[15]}}, s_spike_weight});
    if (sum_wide < 18'sd0) begin
      sat_sum = 16'h0000;
    end else if (sum_wide > 18'sd65535) begin
      sat_sum = 16'hFFFF;
    end else begin
      sat_sum = sum_wide[15:0];
    end
    leaked = (cur_v > leak_rate) ? (cur_v - leak_rate) : 16'h0000;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; soft_reset overrides every state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (soft_rst) begin
      state_d = StClear;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (step_rise && enable) begin
            state_d = StSweep;
            idx_d   = '0;
          end
        end
        StSweep: begin
          if (fire) begin
            state_d = StEmit;
          end else if (last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
        StEmit: begin
          if (m_valid_q && m_spike_ready) begin
            if (last_idx) begin
              state_d = StIdle;
            end else begin
              state_d = StSweep;
              idx_d   = idx_q + ID_W'(1);
            end
          end
        end
        StClear: begin
          if (last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    v_d         = v_q;
    ref_d       = ref_q;
    m_valid_d   = m_valid_q;
    m_id_d      = m_id_q;
    spike_cnt_d = spike_cnt_q;
    ts_d        = ts_q;
    ovr_d       = ovr_q;

    // Events to out-of-range or refractory neurons are consumed without effect
    if (evt_accept && id_in_range && (ref_q[s_spike_id] == '0)) begin
      v_d[s_spike_id] = sat_sum;
    end

    unique case (state_q)
      StSweep: begin
        if (cur_ref != '0) begin
          ref_d[idx_q] = cur_ref - 16'd1;
          v_d[idx_q]   = '0;
        end else if (fire) begin
          v_d[idx_q]   = '0;
          ref_d[idx_q] = refractory_period;
          spike_cnt_d  = spike_cnt_q + 32'd1;
          m_valid_d    = 1'b1;
          m_id_d       = idx_q;
        end else begin
          v_d[idx_q] = leaked;
        end
        if (!fire && last_idx) begin
          ts_d = ts_q + 16'd1;
        end
      end
      StEmit: begin
        if (emit_done) begin
          m_valid_d = 1'b0;
          if (last_idx) begin
            ts_d = ts_q + 16'd1;
          end
        end
      end
      StClear: begin
        v_d[idx_q]   = '0;
        ref_d[idx_q] = '0;
      end
      default: ;
    endcase

    if (step_rise && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end

    if (soft_rst) begin
      m_valid_d   = 1'b0;
      spike_cnt_d = '0;
      ts_d        = '0;
      ovr_d       = 1'b0;
    end
  end

  // Output logic, registered from the next state so flags line up with state_q
  always_comb begin
    ready_d  = (state_d == StIdle) && enable && !soft_rst;
    status_d = {ts_d, 11'b0, ovr_d, (state_d == StClear), (state_d == StEmit),
                (state_d == StSweep), (state_d != StIdle)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q         <= '{default: '0};
      ref_q       <= '{default: '0};
      step_prev_q <= 1'b0;
      ready_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_id_q      <= '0;
      spike_cnt_q <= '0;
      ts_q        <= '0;
      ovr_q       <= 1'b0;
      status_q    <= '0;
    end else begin
      v_q         <= v_d;
      ref_q       <= ref_d;
      step_prev_q <= ctrl_reg[2];
      ready_q     <= ready_d;
      m_valid_q   <= m_valid_d;
      m_id_q      <= m_id_d;
      spike_cnt_q <= spike_cnt_d;
      ts_q        <= ts_d;
      ovr_q       <= ovr_d;
      status_q    <= status_d;
    end
  end

  assign s_spike_ready = ready_q;
  assign m_spike_valid = m_valid_q;
  assign m_spike_id    = m_id_q;
  assign status_reg    = status_q;
  assign spike_count   = spike_cnt_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Self-checking bench for lif_neuron_core: table-driven integration vectors, hand-written
// multi-cycle sequences, and randomized events/steps checked against a behavioural model.
module tb_lif_neuron_core;

  localparam int N  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   ctrl;
  logic [15:0]   leak, thr, rp;
  logic          sv, sr, mv, mr;
  logic [IW-1:0] sid, mid;
  logic [15:0]   sw;
  logic [31:0]   status, scnt;

  always #5 clk = ~clk;

  lif_neuron_core #(.NUM_NEURONS(N), .ID_W(IW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_reg          (ctrl),
    .leak_rate         (leak),
    .threshold         (thr),
    .refractory_period (rp),
    .s_spike_valid     (sv),
    .s_spike_ready     (sr),
    .s_spike_id        (sid),
    .s_spike_weight    (sw),
    .m_spike_valid     (mv),
    .m_spike_ready     (mr),
    .m_spike_id        (mid),
    .status_reg        (status),
    .spike_count       (scnt)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          mvv  [N];
  int          mref [N];
  logic [31:0] m_scnt;
  logic [15:0] m_ts;
  int          exp_spk[$];

  typedef struct {
    int id;
    int wa;
    int na;
    int wb;
    int th;
    int exp_fire;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) wanted %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mvv[i]  = 0;
      mref[i] = 0;
    end
    m_scnt = '0;
    m_ts   = '0;
  endtask

  task automatic model_event(input int id, input int w);
    int t;
    if (mref[id] != 0) return;
    t = mvv[id] + w;
    if (t < 0) t = 0;
    if (t > 65535) t = 65535;
    mvv[id] = t;
  endtask

  task automatic model_step();
    exp_spk.delete();
    for (int i = 0; i < N; i++) begin
      if (mref[i] != 0) begin
        mref[i]--;
        mvv[i] = 0;
      end else if (mvv[i] >= int'(thr)) begin
        exp_spk.push_back(i);
        mvv[i]  = 0;
        mref[i] = int'(rp);
        m_scnt  = m_scnt + 32'd1;
      end else begin
        mvv[i] = (mvv[i] > int'(leak)) ? mvv[i] - int'(leak) : 0;
      end
    end
    m_ts = m_ts + 16'd1;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input int id, input int w);
    logic [31:0] wv;
    bit ok;
    wv  = w;
    sv  = 1'b1;
    sid = id[IW-1:0];
    sw  = wv[15:0];
    ok  = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      ok = sr;
      @(negedge clk);
    end
    sv = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
    if (ok) model_event(id, w);
  endtask

  task automatic compare_spikes(input int got[$]);
    chk("spike_n", got.size(), exp_spk.size());
    for (int i = 0; i < got.size() && i < exp_spk.size(); i++) chk("spike_id", got[i], exp_spk[i]);
    chk("spike_count", scnt, m_scnt);
    chk("timestep", {16'd0, status[31:16]}, {16'd0, m_ts});
  endtask

  task automatic do_step(input bit rand_ready, output int busy, output int nspk);
    int got[$];
    int hold_id;
    bit done;
    hold_id = -1;
    done    = 1'b0;
    busy    = 0;
    ctrl[2] = 1'b1;
    @(negedge clk);
    ctrl[2] = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (!status[0]) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (rand_ready) mr = ($urandom_range(0, 3) != 0);
      if (hold_id >= 0) begin
        chk("valid_held", 32'(mv), 32'd1);
        chk("id_stable", 32'(mid), hold_id);
      end
      if (mv) begin
        if (mr) begin
          got.push_back(int'(mid));
          hold_id = -1;
        end else begin
          hold_id = int'(mid);
        end
      end else begin
        hold_id = -1;
      end
      @(negedge clk);
    end
    mr = 1'b1;
    chk("step_done", 32'(done), 32'd1);
    model_step();
    compare_spikes(got);
    nspk = got.size();
  endtask

  task automatic soft_clear(output int cyc);
    ctrl[1] = 1'b1;
    @(negedge clk);
    ctrl[1] = 1'b0;
    cyc = 0;
    for (int c = 0; c < 500 && status[3]; c++) begin
      cyc++;
      @(negedge clk);
    end
    model_clear();
  endtask

  initial begin
    vec_t vecs[9];
    int busy, nspk, cyc, ne;
    int got[$];

    vecs[0] = '{7, 32767, 3, 0, 65535, 1};  // saturates at 65535
    vecs[1] = '{7, 32767, 2, 0, 65535, 0};  // 65534, just below
    vecs[2] = '{8, 50, 1, -100, 1, 0};      // clamps at 0
    vecs[3] = '{8, 50, 1, -49, 1, 1};       // 1 left
    vecs[4] = '{9, -5, 1, 10, 6, 1};        // clamp then add: 10
    vecs[5] = '{5, 600, 2, 0, 1000, 1};
    vecs[6] = '{5, 600, 1, 0, 1000, 0};
    vecs[7] = '{12, 1000, 1, 0, 1000, 1};   // equal to threshold fires
    vecs[8] = '{12, 999, 1, 0, 1000, 0};

    rst_n = 1'b0;
    ctrl  = '0;
    leak  = 16'd10;
    thr   = 16'd1000;
    rp    = 16'd20;
    sv    = 1'b0;
    sid   = '0;
    sw    = '0;
    mr    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(sr), 32'd0);
    chk("rst_mvalid", 32'(mv), 32'd0);
    chk("rst_mid", 32'(mid), 32'd0);
    chk("rst_status", status, 32'd0);
    chk("rst_scnt", scnt, 32'd0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("ready_disabled", 32'(sr), 32'd0);
    ctrl[0] = 1'b1;
    @(negedge clk);
    chk("ready_enabled", 32'(sr), 32'd1);

    // Fire and refractory
    send(5, 600);
    send(5, 600);
    do_step(1'b0, busy, nspk);
    chk("fire_busy", busy, 65);
    chk("fire_n", nspk, 1);
    chk("fire_scnt", scnt, 32'd1);
    chk("fire_ts", {16'd0, status[31:16]}, 32'd1);
    send(5, 1000);                 // refractory: dropped
    for (int i = 0; i < 19; i++) do_step(1'b0, busy, nspk);
    send(5, 1000);                 // ref still 1: dropped
    do_step(1'b0, busy, nspk);
    chk("refr_hold", nspk, 0);
    send(5, 1000);
    do_step(1'b0, busy, nspk);
    chk("refr_refire", nspk, 1);

    // Leak
    soft_clear(cyc);
    send(3, 25);
    for (int i = 0; i < 3; i++) do_step(1'b0, busy, nspk);
    send(3, 999);                  // would reach 1000 only if leak failed to floor at 0
    send(4, 25);
    do_step(1'b0, busy, nspk);
    chk("leak_floor", nspk, 0);
    send(4, 985);                  // 15 + 985 after one leak
    do_step(1'b0, busy, nspk);
    chk("leak_once", nspk, 1);

    // Integration table
    for (int k = 0; k < 9; k++) begin
      soft_clear(cyc);
      thr = vecs[k].th[15:0];
      for (int j = 0; j < vecs[k].na; j++) send(vecs[k].id, vecs[k].wa);
      if (vecs[k].wb != 0) send(vecs[k].id, vecs[k].wb);
      do_step(1'b0, busy, nspk);
      chk("vec_fire", nspk, vecs[k].exp_fire);
    end

    // Backpressure
    soft_clear(cyc);
    thr = 16'd1000;
    send(1, 1000);
    send(2, 1000);
    mr      = 1'b0;
    ctrl[2] = 1'b1;
    @(negedge clk);
    ctrl[2] = 1'b0;
    for (int c = 0; c < 200 && !mv; c++) @(negedge clk);
    chk("bp_valid_up", 32'(mv), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_valid", 32'(mv), 32'd1);
      chk("bp_hold_id", 32'(mid), 32'd1);
      chk("bp_hold_scnt", scnt, 32'd1);
      @(negedge clk);
    end
    mr = 1'b1;
    for (int c = 0; c < 500 && status[0]; c++) begin
      if (mv) got.push_back(int'(mid));
      @(negedge clk);
    end
    model_step();
    compare_spikes(got);
    chk("bp_scnt_after", scnt, 32'd2);

    // Overrun, then soft reset while a spike waits
    soft_clear(cyc);
    chk("clear_len", cyc, 64);
    send(10, 2000);
    mr      = 1'b0;
    ctrl[2] = 1'b1;
    @(negedge clk);
    ctrl[2] = 1'b0;
    @(negedge clk);
    ctrl[2] = 1'b1;
    @(negedge clk);
    chk("ovr_set", 32'(status[4]), 32'd1);
    ctrl[2] = 1'b0;
    for (int c = 0; c < 200 && !mv; c++) @(negedge clk);
    chk("emit_wait", 32'(status[2]), 32'd1);
    ctrl[1] = 1'b1;
    @(negedge clk);
    ctrl[1] = 1'b0;
    chk("abort_valid", 32'(mv), 32'd0);
    chk("ovr_cleared", 32'(status[4]), 32'd0);
    cyc = 0;
    for (int c = 0; c < 500 && status[3]; c++) begin
      cyc++;
      @(negedge clk);
    end
    chk("abort_clear_len", cyc, 64);
    chk("abort_status", status, 32'd0);
    chk("abort_scnt", scnt, 32'd0);
    model_clear();
    mr  = 1'b1;
    thr = 16'd1;
    do_step(1'b0, busy, nspk);
    chk("post_clear_nofire", nspk, 0);
    chk("post_clear_busy", busy, 64);

    // Randomized events and steps against the model
    soft_clear(cyc);
    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 0) begin
        thr  = 16'($urandom_range(200, 3000));
        leak = 16'($urandom_range(0, 50));
        rp   = 16'($urandom_range(0, 5));
      end
      ne = $urandom_range(0, 6);
      for (int e = 0; e < ne; e++) send($urandom_range(0, N - 1), int'($urandom_range(0, 4000)) - 1000);
      do_step(1'b1, busy, nspk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron_core.md
# lif_neuron_core

Time-stepped leaky-integrate-and-fire neuron array, the compute stage directly downstream of the AXI-Lite register block. It takes that block's control word and neuron parameters (`ctrl_reg`, `leak_rate`, `threshold`, `refractory_period`) and returns `status_reg` and `spike_count` to it. Input spike events are integrated into per-neuron membrane potentials. On each timestep command the block sweeps all neurons to apply leak, threshold and refractory rules, and emits output spikes on a valid/ready stream.

## Interface
- `NUM_NEURONS`, 64: number of neurons; must be ≥2.
- `ID_W`, 6: neuron-id width; must be ≥ $clog2(NUM_NEURONS).
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ctrl_reg` in 32: bit0 enable, bit1 soft_reset (level), bit2 step (rising edge), others ignored.
- `leak_rate` in 16: unsigned decrement applied per timestep.
- `threshold` in 16: unsigned fire threshold.
- `refractory_period` in 16: timesteps a neuron is held after firing.
- `s_spike_valid` in 1 / `s_spike_ready` out 1: input event handshake.
- `s_spike_id` in ID_W: target neuron.
- `s_spike_weight` in 16: signed two's-complement weight.
- `m_spike_valid` out 1 / `m_spike_ready` in 1: output spike handshake.
- `m_spike_id` out ID_W: index of the firing neuron.
- `status_reg` out 32: bit0 busy, bit1 sweeping, bit2 emit_wait, bit3 clearing, bit4 step_overrun (sticky), [15:5]=0, [31:16] timestep_count.
- `spike_count` out 32: total fires, wraps at 2^32.

## Operation
- Per-neuron state: `v[i]` 16-bit unsigned potential; `ref[i]` 16-bit refractory counter.
- FSM states:
  - **IDLE**: `s_spike_ready = enable & ~soft_reset`.
  - **SWEEP**: processes one neuron per cycle, index `idx`.
  - **EMIT**: holds `m_spike_valid` until the handshake completes.
  - **CLEAR**: zeroes one neuron per cycle.
- Event integration (IDLE handshake):
  - If `s_spike_id ≥ NUM_NEURONS`, the event is consumed and ignored.
  - Else if `ref[id] ≠ 0`, the event is consumed and dropped.
  - Else `v[id] = sat(v[id] + weight)`, computed in 18-bit signed and clamped to [0, 65535].
- step_rise = `ctrl_reg[2]` high this cycle and low the previous cycle. The edge register resets to 0.
- IDLE → SWEEP on step_rise & enable & ~soft_reset, with `idx = 0`. step_rise in any other state is ignored and sets status bit4.
- SWEEP, for neuron `idx`, rules apply in this order:
  1. If `ref ≠ 0`: `ref -= 1`, `v = 0`.
  2. Else if `v ≥ threshold`: fire. Set `v = 0`, `ref = refractory_period`, increment `spike_count`, load `m_spike_id = idx`, go to EMIT.
  3. Else `v = max(v − leak_rate, 0)`.
- Advancing from SWEEP or EMIT:
  - Not last neuron: `idx += 1`, continue SWEEP.
  - After `idx = NUM_NEURONS−1`: increment `timestep_count` (wraps at 16 bits) and return to IDLE.
- EMIT: the neuron update is already committed. On `m_spike_valid & m_spike_ready`, advance as above.
- Parameters are sampled live each cycle; software must not change them mid-sweep.
- enable low during SWEEP/EMIT: the sweep still completes.
- soft_reset high in any state:
  - Next cycle, go to CLEAR with `idx = 0`.
  - `m_spike_valid` drops immediately (stream abort permitted).
  - `spike_count`, `timestep_count` and status bit4 clear.
- CLEAR zeroes `v` and `ref` over NUM_NEURONS cycles, then goes to IDLE. Ready stays low while soft_reset is held.
- Reset value of every output, and all state, is 0.

## Timing
- All outputs are registered.
- Event handshake updates `v` at that edge; the sweep sees it the next cycle.
- step_rise sampled in IDLE puts state = SWEEP at the next edge; status bit0/bit1 are high from that edge.
- Sweep latency with no fires: exactly NUM_NEURONS cycles.
- Each fire adds ≥1 cycle. `m_spike_valid` rises the edge after the fire cycle; the sweep resumes the edge after the handshake.
- While `m_spike_valid` is high, `m_spike_id` is stable.
- Spikes within a timestep are emitted in ascending id order.
- `spike_count` increments in the fire cycle, before the handshake.
- soft_reset: CLEAR lasts NUM_NEURONS cycles. IDLE is reached at the earliest NUM_NEURONS+1 cycles after soft_reset is sampled.

## Test plan
- **Reset.** Hold `rst_n` low for 3 cycles → all outputs 0, `s_spike_ready = 0` with enable low.
- **Fire and refractory.** Defaults threshold 1000, leak 10, refractory 20, enable=1. Send two events to id 5 with weight 600, then step.
  - Required: one output spike, id 5; `spike_count = 1`; `timestep_count = 1`; busy for 65 cycles with ready held high.
  - A following event to id 5 is dropped. After 20 further steps, the same event is accepted again.
- **Leak.** Send id 3 weight 25, then step ×3 → `v` goes 15, 5, 0 (saturated); no spike.
- **Saturation.** Send id 7 weight 0x7FFF ×3 → `v = 65535`. With id 8 at `v = 50`, send weight −100 → `v = 0`.
- **Backpressure.** ids 1 and 2 above threshold, `m_spike_ready` low 10 cycles → valid held, id 1 stable, then id 2 emitted. `spike_count = 1` during the stall and 2 after the second fire.
- **Overrun and mid-emit soft reset.** Step during SWEEP → status bit4 = 1. soft_reset pulse during EMIT → `m_spike_valid` drops next cycle; bit3 high for 64 cycles; then `status_reg = 0`, `spike_count = 0`, and all `v` read 0 via a no-fire step.
